// File: rtl/sd_adc_pkg.sv
// Shared constants and helpers for the sigma-delta ADC front end.
// Holds the CIC width/shift arithmetic, the output saturation limits and
// the mapping of the 1-bit modulator stream onto +1/-1 CIC input values.
package sd_adc_pkg;

  // Value fed into the first integrator for a comparator '1' and '0'.
  localparam int BIT_POS = 1;
  localparam int BIT_NEG = -1;

  // Internal CIC word width: the bit growth N*log2(R) plus a sign bit and
  // one bit of headroom so that +full-scale is representable.
  function automatic int cic_width(input int n, input int r_log2);
    return n * r_log2 + 2;
  endfunction

  // Arithmetic right shift that maps the CIC full scale onto the output word.
  function automatic int cic_shift(input int n, input int r_log2, input int out_w);
    return n * r_log2 + 1 - out_w;
  endfunction

  // Two's-complement limits of an out_w-bit signed sample.
  function automatic int sat_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/cic_decimator.sv
// N-stage CIC decimator turning a +1/-1 bit stream into signed samples.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   in_bit_i         modulator bit (1 -> +1, 0 -> -1)
//   in_tick_i        qualifies in_bit_i; integrators advance only on it
//   sample_o         signed OUT_W-bit sample, held between strobes
//   sample_valid_o   one-clk strobe marking a new sample_o
module cic_decimator
  import sd_adc_pkg::*;
#(
  parameter int N      = 3,
  parameter int R_LOG2 = 8,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit_i,
  input  logic             in_tick_i,
  output logic [OUT_W-1:0] sample_o,
  output logic             sample_valid_o
);

  localparam int W     = cic_width(N, R_LOG2);
  localparam int SHIFT = cic_shift(N, R_LOG2, OUT_W);

  localparam logic signed [W-1:0] X_POS  = W'(BIT_POS);
  localparam logic signed [W-1:0] X_NEG  = W'(BIT_NEG);
  localparam logic signed [W-1:0] SAT_HI = W'(sat_max(OUT_W));
  localparam logic signed [W-1:0] SAT_LO = W'(sat_min(OUT_W));
  localparam logic [1:0]          PRIME_DONE = 2'(N);

  // The comb pipeline (N+1 clk) must drain before the next decimation even
  // at one modulator tick per clk, which needs R >= 8 for N <= 3.
  if (R_LOG2 < 3) begin : g_chk_r
    $error("cic_decimator: R_LOG2 must be at least 3");
  end
  if (N < 1 || N > 3) begin : g_chk_n
    $error("cic_decimator: N must be in 1..3 (2-bit prime counter)");
  end
  if (SHIFT < 0) begin : g_chk_shift
    $error("cic_decimator: OUT_W exceeds the CIC resolution");
  end

  logic signed [W-1:0] integ_q [N];
  logic [R_LOG2-1:0]   dec_cnt_q;
  logic signed [W-1:0] comb_in_q;
  logic                dec_strobe_q;

  logic signed [W-1:0] comb_out_q [N];
  logic signed [W-1:0] comb_dly_q [N];
  logic [N-1:0]        comb_vld_q;

  // Stage k reads stage_in[k]/stage_en[k]; index N is the final comb result.
  logic signed [W-1:0] stage_in [N+1];
  logic [N:0]          stage_en;

  logic [1:0]          prime_q;
  logic [OUT_W-1:0]    sample_q;
  logic                sample_valid_q;

  logic signed [W-1:0] x;
  logic signed [W-1:0] y_shifted;
  logic [OUT_W-1:0]    scaled;

  assign x = in_bit_i ? X_POS : X_NEG;

  // Integrators wrap modulo 2^W on purpose; the combs undo the wrap exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) integ_q[k] <= '0;
      dec_cnt_q    <= '0;
      comb_in_q    <= '0;
      dec_strobe_q <= 1'b0;
    end else begin
      dec_strobe_q <= 1'b0;
      if (in_tick_i) begin
        // NOTE: non-blocking assignments make every stage add the value its
        // predecessor held before this tick, which is the cascade we want.
        integ_q[0] <= integ_q[0] + x;
        for (int k = 1; k < N; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
        dec_cnt_q <= dec_cnt_q + R_LOG2'(1);
        if (&dec_cnt_q) begin
          comb_in_q    <= integ_q[N-1];
          dec_strobe_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    stage_in[0] = comb_in_q;
    stage_en[0] = dec_strobe_q;
    for (int k = 0; k < N; k++) begin
      stage_in[k+1] = comb_out_q[k];
      stage_en[k+1] = comb_vld_q[k];
    end
  end

  // Differential delay 1: each stage subtracts the previous decimated input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the comb delay words are reset like any other register so a
      // reset mid-stream cannot leak an old decimated value into new output.
      for (int k = 0; k < N; k++) begin
        comb_out_q[k] <= '0;
        comb_dly_q[k] <= '0;
      end
      comb_vld_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        comb_vld_q[k] <= stage_en[k];
        if (stage_en[k]) begin
          comb_out_q[k] <= stage_in[k] - comb_dly_q[k];
          comb_dly_q[k] <= stage_in[k];
        end
      end
    end
  end

  always_comb begin
    // NOTE: assign the default first so no path through this block leaves
    // scaled unassigned and infers a latch.
    y_shifted = stage_in[N] >>> SHIFT;
    scaled    = y_shifted[OUT_W-1:0];
    if (y_shifted > SAT_HI) begin
      scaled = SAT_HI[OUT_W-1:0];
    end else if (y_shifted < SAT_LO) begin
      scaled = SAT_LO[OUT_W-1:0];
    end
  end

  // The first N results see partially filled combs and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_q        <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      if (stage_en[N]) begin
        if (prime_q == PRIME_DONE) begin
          sample_q       <= scaled;
          sample_valid_q <= 1'b1;
        end else begin
          prime_q <= prime_q + 2'd1;
        end
      end
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;

endmodule

// File: rtl/sigma_delta_adc.sv
// Comparator-based first-order sigma-delta ADC with CIC decimation.
// Ports:
//   clk, rst_n     system clock and asynchronous active-low reset
//   comp_out       raw comparator output, asynchronous to clk
//   comp_neg       registered feedback bit driving the external RC integrator
//   sample         signed OUT_W-bit decimated audio sample
//   sample_valid   one-clk strobe for each new sample
//   bit_tick       one-clk strobe on every modulator tick
module sigma_delta_adc
  import sd_adc_pkg::*;
#(
  parameter int DIV    = 1,
  parameter int R_LOG2 = 8,
  parameter int N      = 3,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             comp_out,
  output logic             comp_neg,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             bit_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (DIV < 1 || DIV > 256) begin : g_chk_div
    $error("sigma_delta_adc: DIV must be in 1..256");
  end

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             bit_tick_q;
  logic             comp_neg_q;
  logic             cic_tick_q;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == CNT_LAST) cnt_d = '0;
  end

  // bit_tick_q is high exactly while cnt_q sits at DIV-1; it is computed
  // from cnt_d so it stays low during reset even when DIV is 1.
  // The CIC takes the bit from comp_neg_q one clk after the tick, so the
  // filtered bit is exactly the bit driven onto the feedback pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      cnt_q      <= '0;
      bit_tick_q <= 1'b0;
      comp_neg_q <= 1'b0;
      cic_tick_q <= 1'b0;
    end else begin
      s1_q       <= comp_out;
      s2_q       <= s1_q;
      cnt_q      <= cnt_d;
      bit_tick_q <= (cnt_d == CNT_LAST);
      cic_tick_q <= bit_tick_q;
      if (bit_tick_q) comp_neg_q <= s2_q;
    end
  end

  cic_decimator #(
    .N      (N),
    .R_LOG2 (R_LOG2),
    .OUT_W  (OUT_W)
  ) u_cic (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_bit_i       (comp_neg_q),
    .in_tick_i      (cic_tick_q),
    .sample_o       (sample),
    .sample_valid_o (sample_valid)
  );

  assign comp_neg = comp_neg_q;
  assign bit_tick = bit_tick_q;

endmodule
